wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Write-back stage that consumes the MEM/WB pipeline register outputs and commits results.
- Drives the GPR write port: selects among ALU result, load data and link address, and suppresses writes to $zero.
- Owns the architectural Hi/Lo register pair, updated from the 64-bit ALU result (mult/div) or the 32-bit ALU result (mthi/mtlo), with optional same-cycle bypass to the mfhi/mflo readers in EX.
- Keeps a retired-instruction counter for the testbench and debug.

Parameters:
- HILO_BYPASS, 1, when 1 HiOut/LoOut show the value being written this cycle; when 0 they show the stored register only.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- MemToRegIn  in  1  1 selects LoadDataIn as write data, 0 selects ALUResultIn.
- LoadDataIn  in  32  load data from the MEM stage.
- ALUResultIn  in  32  32-bit ALU result.
- ALU64ResultIn  in  64  mult/div result; [63:32] is Hi, [31:0] is Lo.
- RegWriteIn  in  1  GPR write request.
- RegDstIn  in  5  GPR destination index.
- LinkIn  in  1  1 selects PC4In as write data (jal/jalr); overrides MemToRegIn.
- PC4In  in  32  link address; 0 marks a bubble.
- HiWriteIn  in  1  Hi write enable.
- LoWriteIn  in  1  Lo write enable.
- HiSrcIn  in  1  0 means Hi takes ALU64ResultIn[63:32]; 1 means Hi takes ALUResultIn.
- LoSrcIn  in  1  0 means Lo takes ALU64ResultIn[31:0]; 1 means Lo takes ALUResultIn.
- CntClr  in  1  synchronous clear of the retire counter.
- RegWriteEn  out  1  GPR write enable.
- RegWriteAddr  out  5  GPR write index.
- RegWriteData  out  32  GPR write data.
- HiOut  out  32  Hi value seen by EX.
- LoOut  out  32  Lo value seen by EX.
- RetireCnt  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (Rst_n=0, asynchronous): Hi=0, Lo=0, RetireCnt=0. HiOut/LoOut read 0 while reset is held, except when HILO_BYPASS=1 and a write enable is asserted. The GPR port is combinational and is not affected by reset.
- Reset mid-operation: state clears immediately. The first posedge after Rst_n rises behaves normally.
- GPR port (combinational, 0 latency):
  - RegWriteAddr = RegDstIn.
  - RegWriteEn = RegWriteIn & (RegDstIn != 0).
  - RegWriteData = LinkIn ? PC4In : (MemToRegIn ? LoadDataIn : ALUResultIn).
  - When LinkIn and MemToRegIn are both set, LinkIn wins.
- Hi/Lo update (registered, 1 cycle):
  - On posedge with HiWriteIn=1, Hi takes the HiSrcIn-selected value.
  - On posedge with LoWriteIn=1, Lo takes the LoSrcIn-selected value.
  - Hi and Lo are independent. Both may update in the same cycle; mult/div asserts both with both Src bits 0.
- Hi/Lo read:
  - HILO_BYPASS=1: HiOut is the incoming Hi value while HiWriteIn=1, otherwise the stored Hi. Lo is handled the same way.
  - HILO_BYPASS=0: HiOut/LoOut are the stored registers, so a write becomes visible 1 cycle later.
- Retire counter, updated on posedge:
  - CntClr=1: RetireCnt = 0. This has priority over a simultaneous retire.
  - Otherwise, if PC4In != 0, RetireCnt increments by 1.
  - Bubbles (PC4In == 0) do not count.
  - The counter wraps modulo 2^CNT_W from all-ones to 0, with no saturation.
- No handshakes: every non-bubble input cycle commits. Stalls upstream appear here as all-zero bubbles, which write nothing and do not count.

Decomposition:
- Shared package (mips_pkg):
  - REG_ZERO = 5'd0, REG_RA = 5'd31.
  - HILO_SRC_ALU64 = 1'b0, HILO_SRC_ALU32 = 1'b1.
  - Constant ALL_ZERO_BUBBLE_PC = 32'd0.
- One sub-module, hilo_regs: the Hi/Lo pair with per-half enables, source muxes and the bypass parameter.
- The GPR mux and the retire counter stay in the top level.

Test Plan:
- Reset: hold Rst_n=0 with HiWriteIn=LoWriteIn=0, then release -> Hi=Lo=0, RetireCnt=0, HiOut=LoOut=0.
- GPR select:
  - RegWriteIn=1, RegDstIn=8, MemToRegIn=1, LoadDataIn=32'hDEADBEEF -> RegWriteEn=1, RegWriteAddr=8, RegWriteData=DEADBEEF.
  - Same inputs plus LinkIn=1, PC4In=32'h0040_0010 -> RegWriteData=00400010.
  - RegDstIn=0 -> RegWriteEn=0.
- mult commit: HiWriteIn=LoWriteIn=1, both Src=0, ALU64ResultIn=64'h0000_0001_FFFF_FFFE.
  - HILO_BYPASS=1: HiOut=00000001 and LoOut=FFFFFFFE in the same cycle.
  - HILO_BYPASS=0: the same values appear on the following cycle.
- mthi only: HiWriteIn=1, HiSrcIn=1, ALUResultIn=32'h1234 -> Hi=00001234, Lo unchanged from the previous scenario (FFFFFFFE).
- Retire count: 5 non-bubble cycles, 3 bubble cycles (PC4In=0), then 1 cycle with CntClr=1 and PC4In!=0 -> RetireCnt goes 5, stays 5, then 0.
- Wrap: with CNT_W=4, 17 non-bubble cycles -> RetireCnt=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the write-back stage.
// Covers register indices, Hi/Lo source selects and the bubble marker.
package mips_pkg;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [4:0]  REG_RA   = 5'd31;

   localparam logic        HILO_SRC_ALU64 = 1'b0;
   localparam logic        HILO_SRC_ALU32 = 1'b1;

   localparam logic [31:0] ALL_ZERO_BUBBLE_PC = 32'd0;

   typedef enum logic {
      HILO_FROM_ALU64 = 1'b0,
      HILO_FROM_ALU32 = 1'b1
   } hiloSrc_e;

   // Picks the incoming half-word for Hi or Lo given its source select.
   function automatic logic [31:0] hiloSelect(input logic        src,
                                              input logic [31:0] alu64Half,
                                              input logic [31:0] alu32);
      return (src == HILO_SRC_ALU32) ? alu32 : alu64Half;
   endfunction

endpackage

// File: rtl/wb_commit_unit_hilo_regs.sv
// Architectural Hi/Lo register pair with per-half enables and source muxes.
// With BYPASS=1 the readers see a value in the same cycle it is written.
module hilo_regs
   import mips_pkg::*;
#(
   parameter bit BYPASS = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        hiWrite_i,
   input  logic        loWrite_i,
   input  logic        hiSrc_i,
   input  logic        loSrc_i,
   input  logic [31:0] alu32_i,
   input  logic [63:0] alu64_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] hiQ, hiD;
   logic [31:0] loQ, loD;
   logic [31:0] hiIncoming;
   logic [31:0] loIncoming;

   always_comb begin
      hiIncoming = hiloSelect(hiSrc_i, alu64_i[63:32], alu32_i);
      loIncoming = hiloSelect(loSrc_i, alu64_i[31:0],  alu32_i);
      hiD = hiWrite_i ? hiIncoming : hiQ;
      loD = loWrite_i ? loIncoming : loQ;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hiQ <= 32'd0;
         loQ <= 32'd0;
      end else begin
         hiQ <= hiD;
         loQ <= loD;
      end
   end

   // The bypass path is purely combinational, so it works even while reset is held.
   always_comb begin
      hi_o = hiQ;
      lo_o = loQ;
      if (BYPASS) begin
         if (hiWrite_i) hi_o = hiIncoming;
         if (loWrite_i) lo_o = loIncoming;
      end
   end

endmodule

// File: rtl/wb_commit_unit.sv
// MIPS write-back stage: GPR write-port mux, Hi/Lo commit and a retire counter.
// Upstream stalls arrive as all-zero bubbles that write nothing and do not count.
module wb_commit_unit
   import mips_pkg::*;
#(
   parameter bit HILO_BYPASS = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             MemToRegIn,
   input  logic [31:0]      LoadDataIn,
   input  logic [31:0]      ALUResultIn,
   input  logic [63:0]      ALU64ResultIn,
   input  logic             RegWriteIn,
   input  logic [4:0]       RegDstIn,
   input  logic             LinkIn,
   input  logic [31:0]      PC4In,
   input  logic             HiWriteIn,
   input  logic             LoWriteIn,
   input  logic             HiSrcIn,
   input  logic             LoSrcIn,
   input  logic             CntClr,
   output logic             RegWriteEn,
   output logic [4:0]       RegWriteAddr,
   output logic [31:0]      RegWriteData,
   output logic [31:0]      HiOut,
   output logic [31:0]      LoOut,
   output logic [CNT_W-1:0] RetireCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cntQ, cntD;
   logic             retire;

   // Link address beats load data, which beats the ALU result.
   always_comb begin
      RegWriteAddr = RegDstIn;
      RegWriteEn   = RegWriteIn && (RegDstIn != REG_ZERO);
      if (LinkIn)
         RegWriteData = PC4In;
      else if (MemToRegIn)
         RegWriteData = LoadDataIn;
      else
         RegWriteData = ALUResultIn;
   end

   hilo_regs #(
      .BYPASS (HILO_BYPASS)
   ) uHiloRegs (
      .clk_i     (Clk),
      .rst_ni    (Rst_n),
      .hiWrite_i (HiWriteIn),
      .loWrite_i (LoWriteIn),
      .hiSrc_i   (HiSrcIn),
      .loSrc_i   (LoSrcIn),
      .alu32_i   (ALUResultIn),
      .alu64_i   (ALU64ResultIn),
      .hi_o      (HiOut),
      .lo_o      (LoOut)
   );

   // Clear wins over a simultaneous retire; the count wraps with no saturation.
   always_comb begin
      retire = (PC4In != ALL_ZERO_BUBBLE_PC);
      cntD   = cntQ;
      if (CntClr)
         cntD = '0;
      else if (retire)
         cntD = cntQ + CNT_ONE;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         cntQ <= '0;
      else
         cntQ <= cntD;
   end

   assign RetireCnt = cntQ;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: bypass, non-bypass and 4-bit counter
// instances share one stimulus stream and are checked against hand values.
module tb_wb_commit_unit;

   logic        Clk;
   logic        Rst_n;
   logic        MemToRegIn;
   logic [31:0] LoadDataIn;
   logic [31:0] ALUResultIn;
   logic [63:0] ALU64ResultIn;
   logic        RegWriteIn;
   logic [4:0]  RegDstIn;
   logic        LinkIn;
   logic [31:0] PC4In;
   logic        HiWriteIn;
   logic        LoWriteIn;
   logic        HiSrcIn;
   logic        LoSrcIn;
   logic        CntClr;

   logic        wenB, wenN, wenW;
   logic [4:0]  waddrB, waddrN, waddrW;
   logic [31:0] wdataB, wdataN, wdataW;
   logic [31:0] hiB, loB, hiN, loN, hiW, loW;
   logic [31:0] cntB, cntN;
   logic [3:0]  cntW;

   int assertCount = 0;
   int failCount   = 0;
   int expCnt      = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   wb_commit_unit #(.HILO_BYPASS(1'b1), .CNT_W(32)) dutB (
      .Clk(Clk), .Rst_n(Rst_n), .MemToRegIn(MemToRegIn), .LoadDataIn(LoadDataIn),
      .ALUResultIn(ALUResultIn), .ALU64ResultIn(ALU64ResultIn), .RegWriteIn(RegWriteIn),
      .RegDstIn(RegDstIn), .LinkIn(LinkIn), .PC4In(PC4In), .HiWriteIn(HiWriteIn),
      .LoWriteIn(LoWriteIn), .HiSrcIn(HiSrcIn), .LoSrcIn(LoSrcIn), .CntClr(CntClr),
      .RegWriteEn(wenB), .RegWriteAddr(waddrB), .RegWriteData(wdataB),
      .HiOut(hiB), .LoOut(loB), .RetireCnt(cntB));

   wb_commit_unit #(.HILO_BYPASS(1'b0), .CNT_W(32)) dutN (
      .Clk(Clk), .Rst_n(Rst_n), .MemToRegIn(MemToRegIn), .LoadDataIn(LoadDataIn),
      .ALUResultIn(ALUResultIn), .ALU64ResultIn(ALU64ResultIn), .RegWriteIn(RegWriteIn),
      .RegDstIn(RegDstIn), .LinkIn(LinkIn), .PC4In(PC4In), .HiWriteIn(HiWriteIn),
      .LoWriteIn(LoWriteIn), .HiSrcIn(HiSrcIn), .LoSrcIn(LoSrcIn), .CntClr(CntClr),
      .RegWriteEn(wenN), .RegWriteAddr(waddrN), .RegWriteData(wdataN),
      .HiOut(hiN), .LoOut(loN), .RetireCnt(cntN));

   wb_commit_unit #(.HILO_BYPASS(1'b1), .CNT_W(4)) dutW (
      .Clk(Clk), .Rst_n(Rst_n), .MemToRegIn(MemToRegIn), .LoadDataIn(LoadDataIn),
      .ALUResultIn(ALUResultIn), .ALU64ResultIn(ALU64ResultIn), .RegWriteIn(RegWriteIn),
      .RegDstIn(RegDstIn), .LinkIn(LinkIn), .PC4In(PC4In), .HiWriteIn(HiWriteIn),
      .LoWriteIn(LoWriteIn), .HiSrcIn(HiSrcIn), .LoSrcIn(LoSrcIn), .CntClr(CntClr),
      .RegWriteEn(wenW), .RegWriteAddr(waddrW), .RegWriteData(wdataW),
      .HiOut(hiW), .LoOut(loW), .RetireCnt(cntW));

   typedef struct {
      string       name;
      logic        memToReg;
      logic [31:0] loadData;
      logic [31:0] aluResult;
      logic        regWrite;
      logic [4:0]  regDst;
      logic        link;
      logic [31:0] pc4;
      logic        expEn;
      logic [31:0] expData;
   } gprVec_t;

   gprVec_t vecs[7];

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      MemToRegIn    = 1'b0;
      LoadDataIn    = 32'd0;
      ALUResultIn   = 32'd0;
      ALU64ResultIn = 64'd0;
      RegWriteIn    = 1'b0;
      RegDstIn      = 5'd0;
      LinkIn        = 1'b0;
      PC4In         = 32'd0;
      HiWriteIn     = 1'b0;
      LoWriteIn     = 1'b0;
      HiSrcIn       = 1'b0;
      LoSrcIn       = 1'b0;
      CntClr        = 1'b0;
   endtask

   // Advances one clock and mirrors the retire counter in the bench model.
   task automatic stepCycle();
      @(posedge Clk);
      if (!Rst_n)
         expCnt = 0;
      else if (CntClr)
         expCnt = 0;
      else if (PC4In != 32'd0)
         expCnt = expCnt + 1;
      #1;
   endtask

   task automatic applyStimulus(input gprVec_t v);
      @(negedge Clk);
      MemToRegIn  = v.memToReg;
      LoadDataIn  = v.loadData;
      ALUResultIn = v.aluResult;
      RegWriteIn  = v.regWrite;
      RegDstIn    = v.regDst;
      LinkIn      = v.link;
      PC4In       = v.pc4;
      #1;
   endtask

   task automatic checkCounters(input string name);
      checkOutput({name, "_cnt32"}, {32'd0, cntB}, 64'(expCnt));
      checkOutput({name, "_cnt4"},  {60'd0, cntW}, 64'(expCnt % 16));
   endtask

   initial begin
      vecs[0] = '{"load",      1'b1, 32'hDEADBEEF, 32'h11111111, 1'b1, 5'd8,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF};
      vecs[1] = '{"link_wins", 1'b1, 32'hDEADBEEF, 32'h11111111, 1'b1, 5'd8,  1'b1, 32'h00400010, 1'b1, 32'h00400010};
      vecs[2] = '{"zero_dst",  1'b1, 32'hDEADBEEF, 32'h11111111, 1'b1, 5'd0,  1'b0, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[3] = '{"alu",       1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 5'd31, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D};
      vecs[4] = '{"no_write",  1'b0, 32'h0,        32'h55AA55AA, 1'b0, 5'd5,  1'b0, 32'h0,        1'b0, 32'h55AA55AA};
      vecs[5] = '{"jal",       1'b0, 32'h0,        32'h77777777, 1'b1, 5'd31, 1'b1, 32'h00400100, 1'b1, 32'h00400100};
      vecs[6] = '{"dst1",      1'b1, 32'h0BADF00D, 32'h0,        1'b1, 5'd1,  1'b0, 32'h0,        1'b1, 32'h0BADF00D};

      clearInputs();
      Rst_n = 1'b0;

      // Reset held: registered state reads zero.
      repeat (3) stepCycle();
      checkOutput("rst_hiB", {32'd0, hiB}, 64'd0);
      checkOutput("rst_loN", {32'd0, loN}, 64'd0);
      checkCounters("rst");
      @(negedge Clk);
      Rst_n = 1'b1;
      stepCycle();
      checkOutput("post_rst_hiN", {32'd0, hiN}, 64'd0);
      checkOutput("post_rst_loB", {32'd0, loB}, 64'd0);
      checkCounters("post_rst");

      // Combinational GPR port vectors, counter held clear.
      CntClr = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         checkOutput({vecs[i].name, "_en"},   {63'd0, wenB}, {63'd0, vecs[i].expEn});
         checkOutput({vecs[i].name, "_addr"}, {59'd0, waddrB}, {59'd0, vecs[i].regDst});
         checkOutput({vecs[i].name, "_data"}, {32'd0, wdataB}, {32'd0, vecs[i].expData});
      end
      stepCycle();
      clearInputs();

      // mult commit: bypass sees it now, non-bypass one cycle later.
      @(negedge Clk);
      HiWriteIn = 1'b1; LoWriteIn = 1'b1;
      ALU64ResultIn = 64'h0000_0001_FFFF_FFFE;
      #1;
      checkOutput("mult_byp_hi",  {32'd0, hiB}, 64'h1);
      checkOutput("mult_byp_lo",  {32'd0, loB}, 64'hFFFFFFFE);
      checkOutput("mult_nbyp_hi", {32'd0, hiN}, 64'h0);
      stepCycle();
      @(negedge Clk);
      clearInputs();
      #1;
      checkOutput("mult_nbyp_hi_late", {32'd0, hiN}, 64'h1);
      checkOutput("mult_nbyp_lo_late", {32'd0, loN}, 64'hFFFFFFFE);

      // mthi only: Lo must keep the mult value.
      HiWriteIn = 1'b1; HiSrcIn = 1'b1; ALUResultIn = 32'h1234;
      ALU64ResultIn = 64'hAAAA_AAAA_BBBB_BBBB;
      #1;
      checkOutput("mthi_byp_hi",  {32'd0, hiB}, 64'h1234);
      checkOutput("mthi_byp_lo",  {32'd0, loB}, 64'hFFFFFFFE);
      checkOutput("mthi_nbyp_hi", {32'd0, hiN}, 64'h1);
      stepCycle();
      @(negedge Clk);
      clearInputs();
      #1;
      checkOutput("mthi_hi", {32'd0, hiN}, 64'h1234);
      checkOutput("mthi_lo", {32'd0, loN}, 64'hFFFFFFFE);

      // mtlo only: Hi must keep the mthi value.
      LoWriteIn = 1'b1; LoSrcIn = 1'b1; ALUResultIn = 32'h5678;
      stepCycle();
      @(negedge Clk);
      clearInputs();
      #1;
      checkOutput("mtlo_hi", {32'd0, hiN}, 64'h1234);
      checkOutput("mtlo_lo", {32'd0, loN}, 64'h5678);

      // Retire counter: clear, 5 retires, 3 bubbles, clear beats retire.
      CntClr = 1'b1;
      stepCycle();
      @(negedge Clk);
      CntClr = 1'b0;
      PC4In  = 32'h0040_0004;
      for (int i = 0; i < 5; i++) stepCycle();
      checkCounters("five_retire");
      @(negedge Clk);
      PC4In = 32'd0;
      for (int i = 0; i < 3; i++) stepCycle();
      checkCounters("bubbles");
      checkOutput("bubble_hold", {32'd0, cntN}, 64'd5);
      @(negedge Clk);
      CntClr = 1'b1;
      PC4In  = 32'h0040_0020;
      stepCycle();
      checkCounters("clr_priority");
      checkOutput("clr_zero", {32'd0, cntB}, 64'd0);

      // Wrap: 17 retires on the 4-bit instance lands on 1.
      @(negedge Clk);
      CntClr = 1'b0;
      for (int i = 0; i < 17; i++) stepCycle();
      checkOutput("wrap_cnt4",  {60'd0, cntW}, 64'd1);
      checkOutput("wrap_cnt32", {32'd0, cntB}, 64'd17);

      // Mid-operation reset clears state immediately; bypass still forwards.
      @(negedge Clk);
      HiWriteIn = 1'b1; HiSrcIn = 1'b1; ALUResultIn = 32'h0000_BEEF;
      #2;
      Rst_n = 1'b0;
      #1;
      checkOutput("midrst_byp_hi",  {32'd0, hiB}, 64'hBEEF);
      checkOutput("midrst_nbyp_hi", {32'd0, hiN}, 64'h0);
      checkOutput("midrst_nbyp_lo", {32'd0, loN}, 64'h0);
      checkOutput("midrst_cnt",     {32'd0, cntB}, 64'd0);
      expCnt = 0;
      @(negedge Clk);
      Rst_n = 1'b1;
      stepCycle();
      checkOutput("after_rst_hi", {32'd0, hiN}, 64'hBEEF);
      checkCounters("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
